row_scan_driver: RTL and testbench

Sequential consumer of the 32×32 monochrome image ROM. It steps the ROM address through rows 0–31 and captures each 32-bit row word. It shifts the word out serially to an external shift-register LED matrix driver, latches it, then displays it for a programmable dwell time. The block sits directly downstream of the image ROM and drives the board-level matrix pins.

---
 rtl/row_scan_pkg.sv | 16 +
 rtl/row_scan_driver_bit_serializer.sv | 63 ++++++
 rtl/row_scan_driver.sv | 113 +++++++++++
 tb/tb_row_scan_driver.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/row_scan_pkg.sv
// Shared constants and state encoding for the LED matrix row scanner.
package row_scan_pkg;

    localparam int ROWS  = 32;
    localparam int COLS  = 32;
    localparam int ROW_W = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        LATCH   = 3'd3,
        DISPLAY = 3'd4
    } scan_state_t;

endpackage

// File: rtl/row_scan_driver_bit_serializer.sv
// Shifts one row word out MSB first; sClk is low then high for CLK_DIV cycles per bit.
module bit_serializer
    import row_scan_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [COLS-1:0] word,
    output logic            sData,
    output logic            sClk,
    output logic            done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]    PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [ROW_W-1:0] BIT_LAST   = ROW_W'(COLS - 1);

    logic [COLS-1:0]  shreg;
    logic [PW-1:0]    phase;
    logic [ROW_W-1:0] bit_cnt;
    logic             busy;
    logic             sclk_q;

    // Combinational so the parent leaves SHIFT on the same edge sClk falls for bit 0.
    assign done  = busy & sclk_q & (phase == '0) & (bit_cnt == BIT_LAST);
    assign sData = shreg[COLS-1];
    assign sClk  = sclk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            sclk_q  <= 1'b0;
        end else if (start) begin
            shreg   <= word;
            phase   <= PHASE_LAST;
            bit_cnt <= '0;
            busy    <= 1'b1;
            sclk_q  <= 1'b0;
        end else if (busy) begin
            if (phase == '0) begin
                phase <= PHASE_LAST;
                if (!sclk_q) begin
                    sclk_q <= 1'b1;
                end else begin
                    sclk_q  <= 1'b0;
                    shreg   <= {shreg[COLS-2:0], 1'b0};
                    bit_cnt <= bit_cnt + ROW_W'(1);
                    if (bit_cnt == BIT_LAST) begin
                        busy <= 1'b0;
                    end
                end
            end else begin
                phase <= phase - PW'(1);
            end
        end
    end

endmodule

// File: rtl/row_scan_driver.sv
// Scans the 32x32 image ROM row by row into a shift-register LED matrix driver.
//
// state   | meaning
// IDLE    | blanked, waiting for en; restarts at row 0
// LOAD    | addRom valid, row word captured into serializer
// SHIFT   | 32 bits clocked out on sData/sClk
// LATCH   | sLatch strobe, rowSel updated
// DISPLAY | oeN low for DWELL cycles, then next row
module row_scan_driver
    import row_scan_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DWELL   = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [ROW_W-1:0] addRom,
    input  logic [COLS-1:0]  dataRom,
    output logic             sData,
    output logic             sClk,
    output logic             sLatch,
    output logic             oeN,
    output logic [ROW_W-1:0] rowSel,
    output logic             frameStart
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

    scan_state_t      state;
    logic [ROW_W-1:0] row;
    logic [DW-1:0]    dwell;
    logic             ser_start;
    logic             ser_done;

    assign ser_start = (state == LOAD);

    bit_serializer #(
        .CLK_DIV (CLK_DIV)
    ) u_ser (
        .clk   (clk),
        .rst   (rst),
        .start (ser_start),
        .word  (dataRom),
        .sData (sData),
        .sClk  (sClk),
        .done  (ser_done)
    );

    // Outputs are set from the transition taken, so each one is a flop rather than a state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            dwell      <= '0;
            addRom     <= '0;
            rowSel     <= '0;
            sLatch     <= 1'b0;
            oeN        <= 1'b1;
            frameStart <= 1'b0;
        end else begin
            sLatch     <= 1'b0;
            frameStart <= 1'b0;
            case (state)
                IDLE: begin
                    oeN <= 1'b1;
                    if (en) begin
                        state      <= LOAD;
                        row        <= '0;
                        addRom     <= '0;
                        frameStart <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (ser_done) begin
                        state  <= LATCH;
                        sLatch <= 1'b1;
                    end
                end
                LATCH: begin
                    rowSel <= row;
                    dwell  <= DWELL_LAST;
                    oeN    <= 1'b0;
                    state  <= DISPLAY;
                end
                DISPLAY: begin
                    if (dwell == '0) begin
                        oeN    <= 1'b1;
                        row    <= row + ROW_W'(1);
                        addRom <= row + ROW_W'(1);
                        if (en) begin
                            state      <= LOAD;
                            frameStart <= (row == ROW_LAST);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        dwell <= dwell - DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_scan_driver.sv
// Directed bench: two instances (default timing and CLK_DIV=1/DWELL=1) driven by a ROM model.
module tb_row_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en;
    logic sel;

    logic [4:0]  a_addRom, b_addRom, a_rowSel, b_rowSel;
    logic [31:0] a_dataRom, b_dataRom;
    logic        a_sData, a_sClk, a_sLatch, a_oeN, a_frameStart;
    logic        b_sData, b_sClk, b_sLatch, b_oeN, b_frameStart;

    logic [4:0]  m_addRom, m_rowSel;
    logic        m_sData, m_sClk, m_sLatch, m_oeN, m_frameStart;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fs_q[$];
    int sl_q[$];

    function automatic logic [31:0] rom_word(input logic [4:0] r);
        logic [31:0] x;
        if (r == 5'd0)  return 32'h200FC000;
        if (r == 5'd31) return 32'h6FE01F80;
        x = {27'd0, r} * 32'h9E3779B9;
        return x ^ 32'h0F0F0F0F;
    endfunction

    assign a_dataRom = rom_word(a_addRom);
    assign b_dataRom = rom_word(b_addRom);

    row_scan_driver #(.CLK_DIV(2), .DWELL(256)) u_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .addRom     (a_addRom),
        .dataRom    (a_dataRom),
        .sData      (a_sData),
        .sClk       (a_sClk),
        .sLatch     (a_sLatch),
        .oeN        (a_oeN),
        .rowSel     (a_rowSel),
        .frameStart (a_frameStart)
    );

    row_scan_driver #(.CLK_DIV(1), .DWELL(1)) u_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .addRom     (b_addRom),
        .dataRom    (b_dataRom),
        .sData      (b_sData),
        .sClk       (b_sClk),
        .sLatch     (b_sLatch),
        .oeN        (b_oeN),
        .rowSel     (b_rowSel),
        .frameStart (b_frameStart)
    );

    assign m_addRom     = sel ? b_addRom     : a_addRom;
    assign m_rowSel     = sel ? b_rowSel     : a_rowSel;
    assign m_sData      = sel ? b_sData      : a_sData;
    assign m_sClk       = sel ? b_sClk       : a_sClk;
    assign m_sLatch     = sel ? b_sLatch     : a_sLatch;
    assign m_oeN        = sel ? b_oeN        : a_oeN;
    assign m_frameStart = sel ? b_frameStart : a_frameStart;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_frameStart === 1'b1) fs_q.push_back(cyc);
        if (m_sLatch === 1'b1)     sl_q.push_back(cyc);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Entered at the negedge of a LOAD cycle; returns at the negedge after the last DISPLAY cycle.
    task automatic row_check(input logic [4:0] ea, input logic efs, input logic [31:0] ew,
                             input int div, input int dw, input int drop_k);
        logic [31:0] cap;
        int          err;
        int          low;
        logic        ps, pd, exp_s;
        chk($sformatf("row%0d_addRom", ea), m_addRom, ea);
        chk($sformatf("row%0d_frameStart", ea), m_frameStart, efs);
        chk($sformatf("row%0d_load_oeN", ea), m_oeN, 1'b1);
        cap = '0; err = 0; ps = 1'b0; pd = 1'b0;
        for (int k = 0; k < 64 * div; k++) begin
            @(negedge clk);
            if (k == drop_k) en = 1'b0;
            exp_s = (((k / div) % 2) == 1);
            if (m_sClk !== exp_s) err++;
            if (m_sClk && ps && (m_sData !== pd)) err++;
            if (m_sClk && !ps) cap = {cap[30:0], m_sData};
            if (m_sLatch !== 1'b0 || m_oeN !== 1'b1) err++;
            ps = m_sClk;
            pd = m_sData;
        end
        chk($sformatf("row%0d_shift_timing", ea), err, 0);
        chk($sformatf("row%0d_word", ea), cap, ew);
        @(negedge clk);
        chk($sformatf("row%0d_latch", ea), {m_sLatch, m_oeN, m_sClk}, 3'b110);
        @(negedge clk);
        chk($sformatf("row%0d_rowSel", ea), m_rowSel, ea);
        low = 0;
        for (int d = 0; d < dw; d++) begin
            if (m_oeN === 1'b0) low++;
            @(negedge clk);
        end
        chk($sformatf("row%0d_oeN_low", ea), low, dw);
        chk($sformatf("row%0d_oeN_end", ea), m_oeN, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic        fs;
        logic [31:0] word;
    } row_vec_t;

    row_vec_t vec[33];

    initial begin
        int base, sb, quiet;
        sel = 1'b0;
        rst = 1'b1;
        en  = 1'b1;

        for (int i = 0; i < 33; i++) begin
            vec[i].addr = 5'(i % 32);
            vec[i].fs   = ((i % 32) == 0);
            vec[i].word = rom_word(5'(i % 32));
        end
        vec[0].word  = 32'h200FC000;
        vec[31].word = 32'h6FE01F80;
        vec[32].word = 32'h200FC000;

        // reset held 3 cycles with en high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset_outs_%0d", i),
                {m_addRom, m_rowSel, m_sData, m_sClk, m_sLatch, m_oeN, m_frameStart},
                {5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        base = fs_q.size();
        rst = 1'b0;
        @(negedge clk);

        // 33 rows: row 0 stream, full frame, wrap back to row 0
        for (int i = 0; i < 33; i++) begin
            row_check(vec[i].addr, vec[i].fs, vec[i].word, 2, 256, -1);
        end
        if (fs_q.size() >= base + 2)
            chk("frame_period", fs_q[base+1] - fs_q[base], 12352);
        else
            chk("frame_count", fs_q.size() - base, 2);

        // en dropped during row 5 shift
        do_reset();
        for (int i = 0; i < 5; i++) row_check(5'(i), (i == 0), rom_word(5'(i)), 2, 256, -1);
        row_check(5'd5, 1'b0, rom_word(5'd5), 2, 256, 10);
        sb = sl_q.size();
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_oeN !== 1'b1 || m_sClk !== 1'b0 || m_frameStart !== 1'b0 || m_sLatch !== 1'b0)
                quiet++;
            @(negedge clk);
        end
        chk("idle_quiet", quiet, 0);
        chk("idle_no_latch", sl_q.size() - sb, 0);
        en = 1'b1;
        @(negedge clk);
        row_check(5'd0, 1'b1, 32'h200FC000, 2, 256, -1);

        // reset at bit 10 of row 3
        do_reset();
        for (int i = 0; i < 3; i++) row_check(5'(i), (i == 0), rom_word(5'(i)), 2, 256, -1);
        chk("abort_row3_addRom", m_addRom, 5'd3);
        sb = sl_q.size();
        for (int k = 0; k <= 40; k++) @(negedge clk);
        chk("abort_pre_sClk", m_sClk, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_reset_outs",
            {m_addRom, m_rowSel, m_sData, m_sClk, m_sLatch, m_oeN, m_frameStart},
            {5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_latch", sl_q.size() - sb, 0);
        chk("abort_restart_addRom", m_addRom, 5'd0);
        chk("abort_restart_fs", m_frameStart, 1'b1);

        // CLK_DIV=1, DWELL=1 instance
        sel = 1'b1;
        do_reset();
        sb = sl_q.size();
        row_check(5'd0, 1'b1, 32'h200FC000, 1, 1, -1);
        for (int i = 1; i < 3; i++) row_check(5'(i), 1'b0, rom_word(5'(i)), 1, 1, -1);
        if (sl_q.size() >= sb + 3) begin
            chk("fast_period_0", sl_q[sb+1] - sl_q[sb], 67);
            chk("fast_period_1", sl_q[sb+2] - sl_q[sb+1], 67);
        end else begin
            chk("fast_latch_count", sl_q.size() - sb, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
